// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline. Runs loads and stores on a req/ack data bus,
// aligns and extends load data, and produces the MEM_WB register set and an upstream stall.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] EX_MEM_pc,
    input  logic [31:0] EX_MEM_alu,
    input  logic [31:0] EX_MEM_rs2,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_is_load,
    input  logic        EX_MEM_is_store,
    output logic        DMEM_req,
    output logic        DMEM_we,
    output logic [31:0] DMEM_addr,
    output logic [3:0]  DMEM_be,
    output logic [31:0] DMEM_wdata,
    input  logic [31:0] DMEM_rdata,
    input  logic        DMEM_ack,
    output logic        MEM_STALL,
    output logic [31:0] MEM_WB_inst,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_data,
    output logic        MEM_WB_we,
    output logic        MEM_misalign,
    output logic        MEM_bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_CUS   = 7'b0001011;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [1:0]  w_off;
    logic        w_is_mem;
    logic        w_aligned;
    logic        w_pending;
    logic        w_misalign;
    logic        w_timeout_hit;
    logic        w_bus_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_wb_we;
    logic [31:0] w_wb_data;

    assign w_opcode = EX_MEM_inst[6:0];
    assign w_funct3 = EX_MEM_inst[14:12];
    assign w_off    = EX_MEM_alu[1:0];
    assign w_is_mem = (EX_MEM_is_load | EX_MEM_is_store) & (EX_MEM_inst != 32'h0);

    always_comb begin
        unique case (w_funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~w_off[0];
            default: w_aligned = (w_off == 2'b00);
        endcase
    end

    assign w_pending  = w_is_mem & w_aligned;
    assign w_misalign = w_is_mem & ~w_aligned;

    // r_count holds the number of earlier cycles req has already been high, so
    // the hit lands on the TIMEOUT-th cycle of the request.
    assign w_timeout_hit = (r_state == S_WAIT) && (r_count == CW'(TIMEOUT - 1));
    assign w_bus_err     = w_pending & ~DMEM_ack & w_timeout_hit;

    assign DMEM_req  = w_pending;
    assign DMEM_we   = EX_MEM_is_store;
    assign DMEM_addr = {EX_MEM_alu[31:2], 2'b00};
    assign MEM_STALL = w_pending & ~DMEM_ack & ~w_timeout_hit;

    always_comb begin
        DMEM_be    = 4'b1111;
        DMEM_wdata = EX_MEM_rs2;
        if (EX_MEM_is_store) begin
            unique case (w_funct3[1:0])
                2'b00: begin
                    DMEM_be    = 4'b0001 << w_off;
                    DMEM_wdata = {4{EX_MEM_rs2[7:0]}};
                end
                2'b01: begin
                    DMEM_be    = w_off[1] ? 4'b1100 : 4'b0011;
                    DMEM_wdata = {2{EX_MEM_rs2[15:0]}};
                end
                default: begin
                    DMEM_be    = 4'b1111;
                    DMEM_wdata = EX_MEM_rs2;
                end
            endcase
        end
    end

    always_comb begin
        unique case (w_off)
            2'd0:    w_byte = DMEM_rdata[7:0];
            2'd1:    w_byte = DMEM_rdata[15:8];
            2'd2:    w_byte = DMEM_rdata[23:16];
            default: w_byte = DMEM_rdata[31:24];
        endcase
        w_half = w_off[1] ? DMEM_rdata[31:16] : DMEM_rdata[15:0];
        unique case (w_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = DMEM_rdata;
        endcase
    end

    assign w_wb_we = (EX_MEM_rd != 5'd0) &&
                     (w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                       OP_LCC, OP_MCC, OP_RCC, OP_CUS});

    always_comb begin
        if (EX_MEM_is_load)
            w_wb_data = w_load_data;
        else if (w_opcode == OP_JAL || w_opcode == OP_JALR)
            w_wb_data = EX_MEM_pc + 32'd4;
        else
            w_wb_data = EX_MEM_alu;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            MEM_WB_inst  <= 32'h0;
            MEM_WB_rd    <= 5'd0;
            MEM_WB_data  <= 32'h0;
            MEM_WB_we    <= 1'b0;
            MEM_misalign <= 1'b0;
            MEM_bus_err  <= 1'b0;
        end else begin
            MEM_misalign <= w_misalign;
            MEM_bus_err  <= w_bus_err;

            unique case (r_state)
                S_IDLE: begin
                    if (w_pending && !DMEM_ack) begin
                        r_state <= S_WAIT;
                        r_count <= CW'(1);
                    end else begin
                        r_count <= '0;
                    end
                end
                S_WAIT: begin
                    if (DMEM_ack || w_timeout_hit || !w_pending) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end
            endcase

            if (MEM_STALL || w_misalign || w_bus_err) begin
                MEM_WB_inst <= 32'h0;
                MEM_WB_rd   <= 5'd0;
                MEM_WB_data <= 32'h0;
                MEM_WB_we   <= 1'b0;
            end else begin
                MEM_WB_inst <= EX_MEM_inst;
                MEM_WB_rd   <= EX_MEM_rd;
                MEM_WB_data <= w_wb_data;
                MEM_WB_we   <= w_wb_we;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed corner cases followed by random
// instructions, each compared against a reference model built from the stage's rules.
module tb_mem_access;

    localparam int TIMEOUT = 16;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_CUS   = 7'b0001011;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] EX_MEM_inst, EX_MEM_pc, EX_MEM_alu, EX_MEM_rs2;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_is_load, EX_MEM_is_store;
    logic        DMEM_req, DMEM_we;
    logic [31:0] DMEM_addr;
    logic [3:0]  DMEM_be;
    logic [31:0] DMEM_wdata, DMEM_rdata;
    logic        DMEM_ack;
    logic        MEM_STALL;
    logic [31:0] MEM_WB_inst;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_data;
    logic        MEM_WB_we, MEM_misalign, MEM_bus_err;

    int total = 0;
    int bad   = 0;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RES(RES),
        .EX_MEM_inst(EX_MEM_inst), .EX_MEM_pc(EX_MEM_pc), .EX_MEM_alu(EX_MEM_alu),
        .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_is_load(EX_MEM_is_load), .EX_MEM_is_store(EX_MEM_is_store),
        .DMEM_req(DMEM_req), .DMEM_we(DMEM_we), .DMEM_addr(DMEM_addr),
        .DMEM_be(DMEM_be), .DMEM_wdata(DMEM_wdata), .DMEM_rdata(DMEM_rdata),
        .DMEM_ack(DMEM_ack), .MEM_STALL(MEM_STALL),
        .MEM_WB_inst(MEM_WB_inst), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_data(MEM_WB_data),
        .MEM_WB_we(MEM_WB_we), .MEM_misalign(MEM_misalign), .MEM_bus_err(MEM_bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic ld,
                         input logic st);
        EX_MEM_inst     = inst;
        EX_MEM_pc       = pc;
        EX_MEM_alu      = alu;
        EX_MEM_rs2      = rs2;
        EX_MEM_rd       = rd;
        EX_MEM_is_load  = ld;
        EX_MEM_is_store = st;
    endtask

    task automatic bubble();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        DMEM_ack = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'h0, f3, rd, op};
    endfunction

    // ---------------- reference model ----------------
    function automatic int unsigned size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] alu);
        return (alu % size_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] alu);
        int unsigned sz = size_of(f3);
        if (!st || sz == 4) return 32'hF;
        if (sz == 1) return 32'h1 << (alu % 4);
        return 32'h3 << (alu % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int unsigned sz = size_of(f3);
        if (sz == 1) return (rs2 & 32'hFF) * 32'h01010101;
        if (sz == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] alu,
                                           input logic [31:0] rdata);
        int unsigned sz = size_of(f3);
        int unsigned bits = 8 * sz;
        logic [31:0] v;
        if (sz == 4) return rdata;
        v = (rdata >> (8 * (alu % 4))) & ((32'h1 << bits) - 32'h1);
        if (!f3[2] && v >= (32'h1 << (bits - 1))) v = v - (32'h1 << bits);
        return v;
    endfunction

    function automatic logic m_we(input logic [31:0] inst, input logic [4:0] rd);
        logic [6:0] op = inst[6:0];
        if (rd == 5'd0) return 1'b0;
        return op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
               op == OP_LCC || op == OP_MCC || op == OP_RCC || op == OP_CUS;
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] inst, input logic [31:0] pc,
                                           input logic [31:0] alu, input bit ld,
                                           input logic [31:0] rdata);
        if (ld) return m_load(inst[14:12], alu, rdata);
        if (inst[6:0] == OP_JAL || inst[6:0] == OP_JALR) return pc + 32'd4;
        return alu;
    endfunction

    // Runs one instruction through the stage with the given ack latency and
    // checks bus signals, stall length and the resulting MEM_WB contents.
    task automatic run_txn(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                           input bit ld, input bit st, input logic [31:0] rdata, input int delay);
        bit mem = (ld || st) && (inst != 32'h0);
        bit al  = m_aligned(inst[14:12], alu);
        drive(inst, pc, alu, rs2, rd, ld, st);
        DMEM_rdata = rdata;
        DMEM_ack   = 1'b0;
        if (mem && al) begin
            for (int c = 0; c <= delay; c++) begin
                DMEM_ack = (c == delay);
                @(negedge CLK);
                check({tag, ":req"}, DMEM_req, 1);
                check({tag, ":stall"}, MEM_STALL, (c < delay));
                if (c == 0) begin
                    check({tag, ":we"}, DMEM_we, st);
                    check({tag, ":addr"}, DMEM_addr, alu & 32'hFFFFFFFC);
                    check({tag, ":be"}, DMEM_be, m_be(st, inst[14:12], alu));
                    if (st) check({tag, ":wdata"}, DMEM_wdata, m_wdata(inst[14:12], rs2));
                end
                step();
                if (c < delay) check({tag, ":stall_bubble"}, MEM_WB_inst, 0);
            end
            DMEM_ack = 1'b0;
        end else begin
            @(negedge CLK);
            check({tag, ":req"}, DMEM_req, 0);
            check({tag, ":stall"}, MEM_STALL, 0);
            step();
        end
        if (mem && !al) begin
            check({tag, ":misalign"}, MEM_misalign, 1);
            check({tag, ":wb_inst"}, MEM_WB_inst, 0);
            check({tag, ":wb_we"}, MEM_WB_we, 0);
        end else begin
            check({tag, ":wb_inst"}, MEM_WB_inst, inst);
            check({tag, ":wb_rd"}, MEM_WB_rd, rd);
            check({tag, ":wb_data"}, MEM_WB_data, m_data(inst, pc, alu, ld, rdata));
            check({tag, ":wb_we"}, MEM_WB_we, m_we(inst, rd));
            check({tag, ":misalign"}, MEM_misalign, 0);
            check({tag, ":bus_err"}, MEM_bus_err, 0);
        end
    endtask

    initial begin
        int n;
        RES = 1'b1;
        DMEM_rdata = 32'h0;
        bubble();

        // Reset state
        step();
        step();
        check("rst_wb_inst", MEM_WB_inst, 0);
        check("rst_wb_rd", MEM_WB_rd, 0);
        check("rst_wb_data", MEM_WB_data, 0);
        check("rst_wb_we", MEM_WB_we, 0);
        check("rst_misalign", MEM_misalign, 0);
        check("rst_bus_err", MEM_bus_err, 0);
        RES = 1'b0;
        @(negedge CLK);
        check("rst_req", DMEM_req, 0);
        check("rst_stall", MEM_STALL, 0);
        step();

        // Directed scenarios
        run_txn("lw_wait3", mk(OP_LCC, 3'b010, 5'd5), 32'h40, 32'h100, 32'h0, 5'd5, 1, 0,
                32'hDEADBEEF, 3);
        check("lw_wait3_const", MEM_WB_data, 32'hDEADBEEF);
        run_txn("lb_sext", mk(OP_LCC, 3'b000, 5'd6), 32'h44, 32'h103, 32'h0, 5'd6, 1, 0,
                32'h80000000, 0);
        check("lb_sext_const", MEM_WB_data, 32'hFFFFFF80);
        run_txn("lbu_zext", mk(OP_LCC, 3'b100, 5'd7), 32'h48, 32'h103, 32'h0, 5'd7, 1, 0,
                32'h80000000, 0);
        check("lbu_zext_const", MEM_WB_data, 32'h00000080);
        run_txn("sh_hi", mk(OP_SCC, 3'b001, 5'd0), 32'h4C, 32'h102, 32'h1234ABCD, 5'd3, 0, 1,
                32'h0, 1);
        check("sh_hi_we_const", MEM_WB_we, 0);
        run_txn("lw_misalign", mk(OP_LCC, 3'b010, 5'd8), 32'h50, 32'h101, 32'h0, 5'd8, 1, 0,
                32'h0, 0);
        bubble();
        step();
        check("misalign_pulse_end", MEM_misalign, 0);
        run_txn("jal_wrap", mk(OP_JAL, 3'b000, 5'd1), 32'hFFFFFFFC, 32'h1234, 32'h0, 5'd1, 0, 0,
                32'h0, 0);
        check("jal_wrap_const", MEM_WB_data, 32'h0);

        // Reset while a load waits for ack; a late ack afterwards is ignored
        drive(mk(OP_LCC, 3'b010, 5'd9), 32'h60, 32'h300, 32'h0, 5'd9, 1'b1, 1'b0);
        DMEM_ack = 1'b0;
        step();
        step();
        check("wait_stalled", MEM_STALL, 1);
        RES = 1'b1;
        step();
        RES = 1'b0;
        bubble();
        check("res_wait_wb_inst", MEM_WB_inst, 0);
        check("res_wait_wb_we", MEM_WB_we, 0);
        check("res_wait_wb_data", MEM_WB_data, 0);
        @(negedge CLK);
        check("res_wait_req", DMEM_req, 0);
        DMEM_ack = 1'b1;
        step();
        check("late_ack_wb_inst", MEM_WB_inst, 0);
        check("late_ack_bus_err", MEM_bus_err, 0);
        DMEM_ack = 1'b0;

        // Store that never gets an ack: bounded wait for the timeout
        drive(mk(OP_SCC, 3'b010, 5'd0), 32'h70, 32'h200, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1);
        n = 0;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            @(negedge CLK);
            if (!MEM_STALL) break;
            n++;
            step();
        end
        check("timeout_stall_cycles", n, TIMEOUT - 1);
        check("timeout_req_last", DMEM_req, 1);
        step();
        check("timeout_bus_err", MEM_bus_err, 1);
        check("timeout_wb_inst", MEM_WB_inst, 0);
        bubble();
        @(negedge CLK);
        check("timeout_req_drop", DMEM_req, 0);
        step();
        check("bus_err_pulse_end", MEM_bus_err, 0);

        // Random instruction mix
        for (int i = 0; i < 80; i++) begin
            logic [31:0] alu, pc, rs2, rdata, inst;
            logic [4:0]  rd;
            logic [2:0]  f3;
            logic [6:0]  op;
            bit ld, st;
            int k, delay;
            alu   = $urandom();
            pc    = $urandom();
            rs2   = $urandom();
            rdata = $urandom();
            rd    = 5'($urandom_range(0, 31));
            f3    = 3'($urandom_range(0, 7));
            delay = $urandom_range(0, 4);
            k     = $urandom_range(0, 9);
            ld    = 0;
            st    = 0;
            case (k)
                0, 1, 2: begin
                    op = OP_LCC;
                    ld = 1;
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
                3, 4: begin
                    op = OP_SCC;
                    st = 1;
                    f3 = 3'($urandom_range(0, 2));
                end
                5: op = ($urandom_range(0, 1) != 0) ? OP_MCC : OP_RCC;
                6: op = ($urandom_range(0, 1) != 0) ? OP_LUI : OP_AUIPC;
                7: op = ($urandom_range(0, 1) != 0) ? OP_JAL : OP_JALR;
                8: op = OP_BCC;
                default: op = ($urandom_range(0, 1) != 0) ? OP_SYS : OP_CUS;
            endcase
            inst = mk(op, f3, rd);
            run_txn($sformatf("rnd%0d", i), inst, pc, alu, rs2, rd, ld, st, rdata, delay);
        end

        bubble();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
